// File: rtl/eth_packet_tx.sv
// eth_packet_tx
//   Ethernet frame transmitter. On an accepted start it streams one byte per
//   clock with control=1: a 14-byte header (dest MAC, src MAC, type/length,
//   all MSB-first), then the payload pulled through a ready/valid handshake,
//   then zero padding up to MIN_PAYLOAD. Every frame (or aborted frame) is
//   followed by GAP idle cycles with control=0 and data=0.
//
// Ports
//   clock        in   1   rising-edge clock
//   reset_n      in   1   asynchronous active-low reset
//   start        in   1   frame request, sampled only while idle
//   dest_mac     in  48   destination MAC, captured on accepted start
//   src_mac      in  48   source MAC, captured on accepted start
//   type_length  in  16   type/length, captured on accepted start
//   pay_len      in  11   payload byte count, captured on accepted start
//   pay_data     in   8   payload byte from the source
//   pay_valid    in   1   pay_data is valid
//   pay_ready    out  1   payload byte is taken this cycle when valid
//   data         out  8   registered output byte
//   control      out  1   registered, 1 = data carries a frame byte
//   busy         out  1   transmitter is not idle
//   frame_done   out  1   pulse in the first gap cycle after a complete frame
//   underrun     out  1   pulse when the source starved the payload
//   len_error    out  1   pulse when a start was rejected for pay_len too large
module eth_packet_tx #(
    parameter int MIN_PAYLOAD = 46,
    parameter int MAX_PAYLOAD = 1500,
    parameter int GAP         = 12
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [47:0] dest_mac,
    input  logic [47:0] src_mac,
    input  logic [15:0] type_length,
    input  logic [10:0] pay_len,
    input  logic [7:0]  pay_data,
    input  logic        pay_valid,
    output logic        pay_ready,
    output logic [7:0]  data,
    output logic        control,
    output logic        busy,
    output logic        frame_done,
    output logic        underrun,
    output logic        len_error
);

    localparam logic [10:0] MIN_L    = 11'(MIN_PAYLOAD);
    localparam logic [10:0] MAX_L    = 11'(MAX_PAYLOAD);
    localparam logic [10:0] GAP_LAST = 11'(GAP - 1);
    localparam logic [10:0] HDR_LAST = 11'd13;

    // The state names the kind of byte currently shown on data/control.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_PAD,
        ST_GAP
    } state_t;

    state_t       state_reg, state_next;
    logic [10:0]  cnt_reg, cnt_next;
    logic [103:0] hdr_reg, hdr_next;     // header bytes still to be sent
    logic [10:0]  len_reg, len_next;
    logic [10:0]  pad_reg, pad_next;
    logic [7:0]   data_reg, data_next;
    logic         control_reg, control_next;
    logic         frame_done_reg, frame_done_next;
    logic         underrun_reg, underrun_next;
    logic         len_error_reg, len_error_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            hdr_reg        <= '0;
            len_reg        <= '0;
            pad_reg        <= '0;
            data_reg       <= '0;
            control_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
            underrun_reg   <= 1'b0;
            len_error_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            hdr_reg        <= hdr_next;
            len_reg        <= len_next;
            pad_reg        <= pad_next;
            data_reg       <= data_next;
            control_reg    <= control_next;
            frame_done_reg <= frame_done_next;
            underrun_reg   <= underrun_next;
            len_error_reg  <= len_error_next;
        end
    end

    // Ready in every cycle whose following output byte is a payload byte:
    // the last header cycle (if there is any payload) and every payload
    // cycle except the final one.
    assign pay_ready = ((state_reg == ST_HEADER) && (cnt_reg == HDR_LAST) && (len_reg != 11'd0)) ||
                       ((state_reg == ST_PAYLOAD) && (cnt_reg != len_reg - 11'd1));

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        hdr_next        = hdr_reg;
        len_next        = len_reg;
        pad_next        = pad_reg;
        data_next       = 8'h00;
        control_next    = 1'b0;
        frame_done_next = 1'b0;
        underrun_next   = 1'b0;
        len_error_next  = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (pay_len > MAX_L) begin
                        len_error_next = 1'b1;
                    end else begin
                        state_next   = ST_HEADER;
                        cnt_next     = '0;
                        len_next     = pay_len;
                        // Only pad short payloads, so the subtraction never wraps.
                        pad_next     = (pay_len < MIN_L) ? (MIN_L - pay_len) : 11'd0;
                        data_next    = dest_mac[47:40];
                        control_next = 1'b1;
                        hdr_next     = {dest_mac[39:0], src_mac, type_length};
                    end
                end
            end

            ST_HEADER: begin
                if (cnt_reg != HDR_LAST) begin
                    cnt_next     = cnt_reg + 11'd1;
                    data_next    = hdr_reg[103:96];
                    control_next = 1'b1;
                    hdr_next     = {hdr_reg[95:0], 8'h00};
                end else begin
                    cnt_next = '0;
                    if (len_reg == 11'd0) begin
                        state_next   = ST_PAD;
                        control_next = 1'b1;
                    end else if (pay_valid) begin
                        state_next   = ST_PAYLOAD;
                        data_next    = pay_data;
                        control_next = 1'b1;
                    end else begin
                        state_next    = ST_GAP;
                        underrun_next = 1'b1;
                    end
                end
            end

            ST_PAYLOAD: begin
                if (cnt_reg != len_reg - 11'd1) begin
                    if (pay_valid) begin
                        cnt_next     = cnt_reg + 11'd1;
                        data_next    = pay_data;
                        control_next = 1'b1;
                    end else begin
                        state_next    = ST_GAP;
                        cnt_next      = '0;
                        underrun_next = 1'b1;
                    end
                end else begin
                    cnt_next = '0;
                    if (pad_reg != 11'd0) begin
                        state_next   = ST_PAD;
                        control_next = 1'b1;
                    end else begin
                        state_next      = ST_GAP;
                        frame_done_next = 1'b1;
                    end
                end
            end

            ST_PAD: begin
                if (cnt_reg != pad_reg - 11'd1) begin
                    cnt_next     = cnt_reg + 11'd1;
                    control_next = 1'b1;
                end else begin
                    state_next      = ST_GAP;
                    cnt_next        = '0;
                    frame_done_next = 1'b1;
                end
            end

            ST_GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 11'd1;
                end
            end

            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign data       = data_reg;
    assign control    = control_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign frame_done = frame_done_reg;
    assign underrun   = underrun_reg;
    assign len_error  = len_error_reg;

endmodule

// File: tb/tb_eth_packet_tx.sv
// Testbench for eth_packet_tx: directed frames checked every cycle against a
// byte-stream model built from the frame format rules.
module tb_eth_packet_tx;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [47:0] dest_mac;
    logic [47:0] src_mac;
    logic [15:0] type_length;
    logic [10:0] pay_len;
    logic [7:0]  pay_data;
    logic        pay_valid;
    logic        pay_ready;
    logic [7:0]  data;
    logic        control;
    logic        busy;
    logic        frame_done;
    logic        underrun;
    logic        len_error;

    eth_packet_tx dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .dest_mac    (dest_mac),
        .src_mac     (src_mac),
        .type_length (type_length),
        .pay_len     (pay_len),
        .pay_data    (pay_data),
        .pay_valid   (pay_valid),
        .pay_ready   (pay_ready),
        .data        (data),
        .control     (control),
        .busy        (busy),
        .frame_done  (frame_done),
        .underrun    (underrun),
        .len_error   (len_error)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Expected outputs for one cycle.
    typedef struct packed {
        logic       ctrl;
        logic [7:0] data;
        logic       busy;
        logic       fd;
        logic       ur;
        logic       le;
        logic       rdy;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] pay_mem [0:1499];
    int         src_idx    = 0;
    int         n_src      = 0;
    int         stall_at   = 9999;
    int         n_checks   = 0;
    int         n_fail     = 0;
    int         ctrl_total = 0;
    int         base;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, required %0h", name, $time, act, req);
        end
    endtask

    // Model: the full per-cycle output sequence of one start request.
    task automatic expect_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] tl,
                                input int len, input int stall);
        logic [7:0] hdr [0:13];
        exp_t       e;
        int         n_send;
        bit         cut;
        for (int b = 0; b < 6; b++) begin
            hdr[b]     = d[47-8*b -: 8];
            hdr[6 + b] = s[47-8*b -: 8];
        end
        hdr[12] = tl[15:8];
        hdr[13] = tl[7:0];
        if (len > 1500) begin
            e    = '0;
            e.le = 1'b1;
            exp_q.push_back(e);
            return;
        end
        cut    = (stall < len);
        n_send = cut ? 14 + stall : 14 + ((len > 46) ? len : 46);
        for (int i = 0; i < n_send; i++) begin
            e      = '0;
            e.ctrl = 1'b1;
            e.busy = 1'b1;
            if (i < 14)            e.data = hdr[i];
            else if (i - 14 < len) e.data = pay_mem[i-14];
            else                   e.data = 8'h00;
            e.rdy = (i + 1 >= 14) && (i + 1 < 14 + len) && (i + 1 <= 14 + stall);
            exp_q.push_back(e);
        end
        for (int g = 0; g < 12; g++) begin
            e      = '0;
            e.busy = 1'b1;
            if (g == 0) begin
                e.fd = !cut;
                e.ur = cut;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic kick(input logic [47:0] d, input logic [47:0] s, input logic [15:0] tl,
                        input int len, input int stall);
        src_idx     = 0;
        n_src       = len;
        stall_at    = stall;
        dest_mac    = d;
        src_mac     = s;
        type_length = tl;
        pay_len     = 11'(len);
        start       = 1'b1;
        $display("TX start dest=%012h src=%012h tl=%04h len=%0d stall=%0d", d, s, tl, len, stall);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(negedge clock);
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clock);
    endtask

    // Payload source: offers pay_mem bytes in order, withholding valid at stall_at.
    initial begin
        pay_valid = 1'b0;
        pay_data  = 8'h00;
        forever begin
            @(negedge clock);
            pay_valid = (src_idx < n_src) && (src_idx != stall_at);
            pay_data  = (src_idx < 1500) ? pay_mem[src_idx] : 8'h00;
            #4;
            if (pay_ready && pay_valid) src_idx++;
        end
    end

    // Per-cycle compare against the model; an empty model means idle outputs.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = '0;
            a = {control, data, busy, frame_done, underrun, len_error, pay_ready};
            if (control) ctrl_total++;
            check("cycle", 32'(a), 32'(e));
        end
    end

    initial begin
        reset_n     = 1'b1;
        start       = 1'b0;
        dest_mac    = '0;
        src_mac     = '0;
        type_length = '0;
        pay_len     = '0;
        #2 reset_n  = 1'b0;
        tick(3);
        check("reset_state", {control, data, busy, frame_done, underrun, len_error, pay_ready}, 0);
        reset_n = 1'b1;
        tick(1);

        // 1: minimum-size payload, no padding
        for (int i = 0; i < 46; i++) pay_mem[i] = 8'(i + 1);
        base = ctrl_total;
        expect_frame(48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 46, 9999);
        check("t1_model_size", exp_q.size(), 72);
        check("t1_model_first", exp_q[0].data, 8'h0A);
        check("t1_model_tl_hi", exp_q[12].data, 8'h08);
        check("t1_model_pay0", exp_q[14].data, 8'h01);
        check("t1_model_last", exp_q[59].data, 8'h2E);
        check("t1_model_done", exp_q[60].fd, 1);
        kick(48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 46, 9999);
        drain();
        check("t1_ctrl_cycles", ctrl_total - base, 60);

        // 2: short payload padded to minimum
        for (int i = 0; i < 10; i++) pay_mem[i] = 8'(8'hA0 + i);
        base = ctrl_total;
        expect_frame(48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 10, 9999);
        check("t2_model_lastpay", exp_q[23].data, 8'hA9);
        check("t2_model_pad", exp_q[24].data, 8'h00);
        check("t2_model_ctrl59", exp_q[59].ctrl, 1);
        check("t2_model_ctrl60", exp_q[60].ctrl, 0);
        kick(48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 10, 9999);
        drain();
        check("t2_ctrl_cycles", ctrl_total - base, 60);

        // 3: empty payload, one-short payload, max payload, oversize
        base = ctrl_total;
        expect_frame(48'hFFFFFFFFFFFF, 48'h020000000001, 16'h88B5, 0, 9999);
        check("t3a_model_rdy13", exp_q[13].rdy, 0);
        kick(48'hFFFFFFFFFFFF, 48'h020000000001, 16'h88B5, 0, 9999);
        drain();
        check("t3a_ctrl_cycles", ctrl_total - base, 60);

        for (int i = 0; i < 45; i++) pay_mem[i] = 8'(8'hC0 + i);
        base = ctrl_total;
        expect_frame(48'h001122334455, 48'h66778899AABB, 16'h002D, 45, 9999);
        kick(48'h001122334455, 48'h66778899AABB, 16'h002D, 45, 9999);
        drain();
        check("t3b_ctrl_cycles", ctrl_total - base, 60);

        for (int i = 0; i < 1500; i++) pay_mem[i] = 8'(i) ^ 8'h5A;
        base = ctrl_total;
        expect_frame(48'h123456789ABC, 48'hDEF012345678, 16'h05DC, 1500, 9999);
        check("t3c_model_size", exp_q.size(), 1526);
        kick(48'h123456789ABC, 48'hDEF012345678, 16'h05DC, 1500, 9999);
        drain();
        check("t3c_ctrl_cycles", ctrl_total - base, 1514);

        base = ctrl_total;
        expect_frame(48'h123456789ABC, 48'hDEF012345678, 16'h05DD, 1501, 9999);
        kick(48'h123456789ABC, 48'hDEF012345678, 16'h05DD, 1501, 9999);
        drain();
        check("t3d_ctrl_cycles", ctrl_total - base, 0);

        // 4: source starves at the fifth payload byte
        for (int i = 0; i < 46; i++) pay_mem[i] = 8'(i + 1);
        base = ctrl_total;
        expect_frame(48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 46, 4);
        check("t4_model_size", exp_q.size(), 30);
        check("t4_model_rdy17", exp_q[17].rdy, 1);
        check("t4_model_underrun", exp_q[18].ur, 1);
        kick(48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 46, 4);
        drain();
        check("t4_ctrl_cycles", ctrl_total - base, 18);

        // 5: start during HEADER and GAP is ignored
        for (int i = 0; i < 20; i++) pay_mem[i] = 8'(8'h30 + i);
        base = ctrl_total;
        expect_frame(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h0014, 20, 9999);
        kick(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h0014, 20, 9999);
        tick(3);
        dest_mac = 48'h0; pay_len = 11'd5; start = 1'b1;
        $display("TX start while busy (header)");
        tick(1);
        start = 1'b0;
        tick(61);
        start = 1'b1;
        $display("TX start while busy (gap)");
        tick(1);
        start = 1'b0;
        drain();
        check("t5_ctrl_cycles", ctrl_total - base, 60);
        base = ctrl_total;
        expect_frame(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h0014, 20, 9999);
        kick(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h0014, 20, 9999);
        drain();
        check("t5_next_ctrl_cycles", ctrl_total - base, 60);

        // 6: asynchronous reset mid-payload
        for (int i = 0; i < 46; i++) pay_mem[i] = 8'(i + 1);
        expect_frame(48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 46, 9999);
        kick(48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 46, 9999);
        tick(33);
        check("t6_byte20", data, 8'd20);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        $display("TX async reset asserted");
        #1;
        check("t6_async_reset", {control, data, busy, pay_ready}, 0);
        tick(2);
        reset_n = 1'b1;
        tick(1);
        base = ctrl_total;
        expect_frame(48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 46, 9999);
        kick(48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 46, 9999);
        drain();
        check("t6_ctrl_cycles", ctrl_total - base, 60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
